hex_scan_ctrl: RTL and testbench

Time-multiplexed controller for a four-digit seven-segment display. It shares a single hex-to-seven-segment decoder across all four digits. The block sits between the CPU's output register and the board display pins. It latches a 16-bit value through a load/ack handshake and commits it only on frame boundaries, so digits never tear. It scans the digits with a programmable refresh divider and inserts one dead-time cycle between digits.

---
 rtl/hex_scan_ctrl.sv | 112 +++++++++++
 tb/tb_hex_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Four-digit seven-segment scan controller; new values commit only on frame boundaries.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan_ctrl #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        ack,
  output logic [3:0]  nib,
  input  logic [6:0]  hex,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  localparam int PW = $clog2(DIV);

  typedef enum logic [1:0] {DARK, SCAN, GAP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] pre_q;
  logic          ack_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          tick;
  logic          commit;
  logic [3:0]    blank;

`ifdef HEX_SCAN_LZB_EN
  assign blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lzb
    assign blank[gi] = (disp_q[15:4*gi] == '0);
  end
`else
  assign blank = 4'h0;
`endif

  assign tick = (pre_q == PW'(DIV - 1));
  assign nib  = disp_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    case (state_q)
      DARK: begin
        if (tick && pend_q) begin
          commit  = 1'b1;
          idx_d   = 2'd0;
          state_d = GAP;
        end
      end
      SCAN: begin
        if (tick) begin
          commit  = pend_q && (idx_q == 2'd3);
          idx_d   = idx_q + 2'd1;
          state_d = GAP;
        end
      end
      GAP:     state_d = SCAN;
      default: state_d = DARK;
    endcase

    // A load coinciding with a commit lands in shadow after the old value is taken.
    disp_d   = commit ? shadow_q : disp_q;
    shadow_d = load ? data_in : shadow_q;
    pend_d   = load | (pend_q & ~commit);

    // Segment/anode pins are registered, so the decoder settles during the prior cycle.
    an_d  = 4'hF;
    seg_d = 7'h7F;
    if (state_q == SCAN) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank[idx_q] ? 7'h7F : hex;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DARK;
      disp_q   <= 16'h0000;
      shadow_q <= 16'h0000;
      pend_q   <= 1'b0;
      idx_q    <= 2'd0;
      pre_q    <= '0;
      ack_q    <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= 4'hF;
    end else begin
      state_q  <= state_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      pre_q    <= tick ? '0 : pre_q + PW'(1);
      ack_q    <= commit;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign busy = pend_q;
  assign ack  = ack_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl (DIV=4): table-driven frames plus hand-written
// handshake corner cases, with a scoreboard of expected frames popped on each ack.
module tb_hex_scan_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        busy, ack;
  logic [3:0]  nib, an;
  logic [6:0]  hex, seg;

  hex_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .busy(busy), .ack(ack), .nib(nib), .hex(hex), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign hex = dec7(nib);

  // Expected segments packed {digit3, digit2, digit1, digit0}.
  function automatic logic [27:0] frame_exp(input logic [15:0] v);
    logic [27:0] r;
    for (int k = 0; k < 4; k++) begin
      r[7*k +: 7] = dec7(v[4*k +: 4]);
`ifdef HEX_SCAN_LZB_EN
      if (k > 0 && (v >> (4*k)) == 16'h0) r[7*k +: 7] = 7'h7F;
`endif
    end
    return r;
  endfunction

  typedef struct {
    logic [15:0] din;
    logic [27:0] exp_plain;
    logic [27:0] exp_lzb;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int ack_seen = 0;
  int ack_used = 0;
  int last_ack_cyc = 0;
  logic [27:0] exp_q[$];
  logic [27:0] cur_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (ack === 1'b1) begin
      ack_seen++;
      last_ack_cyc = cyc;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [27:0] e, input bit fresh);
    load = 1'b1;
    data_in = v;
    $display("load %04h (fresh=%0d) at cycle %0d", v, fresh, cyc);
    if (fresh || exp_q.size() == 0) exp_q.push_back(e);
    else exp_q[exp_q.size()-1] = e;
  endtask

  task automatic wait_an(input logic [3:0] val, input string name);
    int n = 0;
    do begin step(); n++; end while (an !== val && n < 8*DIV);
    if (an !== val) chk({name, " wait an"}, {28'h0, an}, {28'h0, val});
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (ack_seen == ack_used && n < 8*DIV + 4) begin step(); n++; end
    if (ack_seen == ack_used) begin
      n_checks++;
      $display("FAIL %s: got no ack expected ack within %0d cycles", name, n);
      return;
    end
    ack_used++;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got unexpected ack expected none (scoreboard empty)", name);
    end else begin
      cur_exp = exp_q.pop_front();
      $display("ack %s at cycle %0d", name, last_ack_cyc);
    end
  endtask

  task automatic capture(input logic [27:0] e, input string name);
    int n = 0;
    do begin step(); n++; end while (an !== 4'hE && n < 8*DIV);
    if (an !== 4'hE) begin
      chk({name, " frame start"}, {28'h0, an}, 32'hE);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < DIV-1; j++) begin
        if (k != 0 || j != 0) step();
        chk({name, " lit"}, {21'h0, an, seg}, {21'h0, ~(4'b0001 << k), e[7*k +: 7]});
      end
      step();
      chk({name, " gap"}, {21'h0, an, seg}, {21'h0, 4'hF, 7'h7F});
    end
    $display("frame %s checked at cycle %0d", name, cyc);
  endtask

  initial begin
    int c1;
    bit bad;
    vecs[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'hABCD, {7'h08, 7'h03, 7'h46, 7'h21}, {7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[2] = '{16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{16'h00A3, {7'h40, 7'h40, 7'h08, 7'h30}, {7'h7F, 7'h7F, 7'h08, 7'h30}};
    vecs[4] = '{16'hF00F, {7'h0E, 7'h40, 7'h40, 7'h0E}, {7'h0E, 7'h40, 7'h40, 7'h0E}};
    vecs[5] = '{16'h0E70, {7'h40, 7'h06, 7'h78, 7'h40}, {7'h7F, 7'h06, 7'h78, 7'h40}};

    // Reset held with load toggling.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset outputs", {15'h0, an, seg, busy, ack, nib}, {15'h0, 4'hF, 7'h7F, 1'b0, 1'b0, 4'h0});
      load = ~load;
      data_in = 16'($urandom);
    end
    load = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("dark idle", {25'h0, an, busy, ack}, {25'h0, 4'hF, 1'b0, 1'b0});
    end

    // First load from DARK.
    do_load(16'h1234, frame_exp(16'h1234), 1'b1);
    step();
    load = 1'b0;
    chk("busy after load", {31'h0, busy}, 32'h1);
    wait_ack("first");
    chk("ack with busy low", {30'h0, ack, busy}, 32'h2);
    step();
    chk("ack single pulse", {31'h0, ack}, 32'h0);
    capture(cur_exp, "first 1234");

    // Tear-free update while digit 1 is lit.
    wait_an(4'hD, "tear");
    do_load(16'hABCD, frame_exp(16'hABCD), 1'b1);
    step();
    load = 1'b0;
    chk("tear digit1 old", {21'h0, an, seg}, {21'h0, 4'hD, 7'h30});
    chk("tear busy", {31'h0, busy}, 32'h1);
    wait_an(4'hB, "tear");
    chk("tear digit2 old", {25'h0, seg}, {25'h0, 7'h24});
    wait_an(4'h7, "tear");
    chk("tear digit3 old", {25'h0, seg}, {25'h0, 7'h79});
    wait_ack("tear");
    chk("tear ack after digit3", {27'h0, ack, an}, {27'h0, 1'b1, 4'h7});
    capture(cur_exp, "tear ABCD");

    // Minimum latency: load just before the frame-boundary tick.
    wait_an(4'h7, "minlat");
    do_load(16'h5A5A, frame_exp(16'h5A5A), 1'b1);
    step();
    load = 1'b0;
    chk("minlat no ack at +1", {31'h0, ack}, 32'h0);
    step();
    chk("minlat ack at +2", {31'h0, ack}, 32'h1);
    wait_ack("minlat");
    capture(cur_exp, "minlat 5A5A");

    // Overwrite before the boundary: one ack, last value wins.
    wait_an(4'hE, "overwrite");
    do_load(16'h1111, frame_exp(16'h1111), 1'b1);
    step();
    load = 1'b0;
    step();
    do_load(16'h2222, frame_exp(16'h2222), 1'b0);
    step();
    load = 1'b0;
    wait_ack("overwrite");
    capture(cur_exp, "overwrite 2222");
    for (int i = 0; i < 8*DIV; i++) step();
    chk("overwrite single ack", ack_seen, ack_used);
    chk("overwrite busy idle", {31'h0, busy}, 32'h0);

    // Load in the exact commit cycle.
    wait_an(4'hE, "commitcyc");
    do_load(16'h5678, frame_exp(16'h5678), 1'b1);
    step();
    load = 1'b0;
    wait_an(4'h7, "commitcyc");
    step();
    do_load(16'h9ABC, frame_exp(16'h9ABC), 1'b1);
    step();
    load = 1'b0;
    chk("commitcyc ack busy", {30'h0, ack, busy}, 32'h3);
    wait_ack("commitcyc first");
    c1 = last_ack_cyc;
    capture(cur_exp, "commitcyc 5678");
    wait_ack("commitcyc second");
    chk("commitcyc ack spacing", last_ack_cyc - c1, 4*DIV);
    capture(cur_exp, "commitcyc 9ABC");

    // Reset while a value is pending.
    wait_an(4'hE, "rstpend");
    do_load(16'hFFFF, frame_exp(16'hFFFF), 1'b1);
    step();
    load = 1'b0;
    step();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    c1 = ack_seen;
    bad = 1'b0;
    for (int i = 0; i < 12*DIV; i++) begin
      step();
      if (an !== 4'hF || seg !== 7'h7F || busy !== 1'b0 || nib !== 4'h0) bad = 1'b1;
    end
    chk("rstpend no ack", ack_seen, c1);
    chk("rstpend stays dark", {31'h0, bad}, 32'h0);
    ack_used = ack_seen;

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
`ifdef HEX_SCAN_LZB_EN
      do_load(vecs[i].din, vecs[i].exp_lzb, 1'b1);
`else
      do_load(vecs[i].din, vecs[i].exp_plain, 1'b1);
`endif
      step();
      load = 1'b0;
      wait_ack($sformatf("table %0d", i));
      capture(cur_exp, $sformatf("table %04h", vecs[i].din));
    end
    chk("all acks expected", ack_seen, ack_used);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
